// File: rtl/wash_cycle_ctrl_if.sv
// Front-panel bus of the wash sequencer: operator inputs in, run status out.
interface wash_cycle_ctrl_if;
  logic       start;
  logic [1:0] mode;
  logic [9:0] bal_in;
  logic       pause;
  logic [9:0] bal_out;
  logic [7:0] secs;
  logic [2:0] phase;
  logic [2:0] led;
  logic       busy;
  logic       done;

  modport master (
    output start, mode, bal_in, pause,
    input  bal_out, secs, phase, led, busy, done
  );

  modport slave (
    input  start, mode, bal_in, pause,
    output bal_out, secs, phase, led, busy, done
  );
endinterface

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine run sequencer: balance check and deduction, then WASH/RINSE/SPIN countdown.
// Optional pause/blink feature is built when WCC_PAUSE_EN is defined.
module wash_cycle_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned COST0    = 10,
  parameter int unsigned COST1    = 20,
  parameter int unsigned COST2    = 30,
  parameter int unsigned COST3    = 5,
  parameter int unsigned T_W0     = 10,
  parameter int unsigned T_R0     = 5,
  parameter int unsigned T_S0     = 5,
  parameter int unsigned T_W1     = 20,
  parameter int unsigned T_R1     = 10,
  parameter int unsigned T_S1     = 10,
  parameter int unsigned T_W2     = 30,
  parameter int unsigned T_R2     = 15,
  parameter int unsigned T_S2     = 15,
  parameter int unsigned T_W3     = 0,
  parameter int unsigned T_R3     = 0,
  parameter int unsigned T_S3     = 10
) (
  input logic               clk,
  input logic               rst,
  wash_cycle_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Encoding doubles as the phase output code.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWash  = 3'd1,
    StRinse = 3'd2,
    StSpin  = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  function automatic logic [9:0] cost(input logic [1:0] m);
    logic [9:0] c;
    case (m)
      2'd0:    c = 10'(COST0);
      2'd1:    c = 10'(COST1);
      2'd2:    c = 10'(COST2);
      default: c = 10'(COST3);
    endcase
    return c;
  endfunction

  function automatic logic [7:0] phase_time(input logic [1:0] m, input state_e st);
    logic [7:0] t;
    t = 8'd0;
    case (st)
      StWash: begin
        case (m)
          2'd0:    t = 8'(T_W0);
          2'd1:    t = 8'(T_W1);
          2'd2:    t = 8'(T_W2);
          default: t = 8'(T_W3);
        endcase
      end
      StRinse: begin
        case (m)
          2'd0:    t = 8'(T_R0);
          2'd1:    t = 8'(T_R1);
          2'd2:    t = 8'(T_R2);
          default: t = 8'(T_R3);
        endcase
      end
      StSpin: begin
        case (m)
          2'd0:    t = 8'(T_S0);
          2'd1:    t = 8'(T_S1);
          2'd2:    t = 8'(T_S2);
          default: t = 8'(T_S3);
        endcase
      end
      default: t = 8'd0;
    endcase
    return t;
  endfunction

  // First phase at or after 'from' with a nonzero time; zero-length phases are skipped.
  function automatic state_e first_phase(input logic [1:0] m, input state_e from);
    state_e st;
    st = StDone;
    if (from == StWash && phase_time(m, StWash) != 8'd0) begin
      st = StWash;
    end else if ((from == StWash || from == StRinse) && phase_time(m, StRinse) != 8'd0) begin
      st = StRinse;
    end else if (phase_time(m, StSpin) != 8'd0) begin
      st = StSpin;
    end
    return st;
  endfunction

  state_e            state_q, state_d, nxt;
  logic [7:0]        secs_q, secs_d;
  logic [9:0]        bal_q, bal_d;
  logic [1:0]        mode_q, mode_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              tick, busy, hold;
  logic [2:0]        led_on;
`ifdef WCC_PAUSE_EN
  logic              paused_q, paused_d;
  logic [CntW-1:0]   blink_q, blink_d;
`endif

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));
  assign busy = (state_q == StWash) || (state_q == StRinse) || (state_q == StSpin);

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    bal_d   = bal_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    cnt_d   = tick ? '0 : cnt_q + CntW'(1);
    hold    = 1'b0;
    nxt     = StDone;
`ifdef WCC_PAUSE_EN
    paused_d = paused_q;
    blink_d  = blink_q;
    // A pause pulse swallows any tick in the same cycle.
    if (busy && bus.pause) begin
      paused_d = ~paused_q;
      blink_d  = '0;
      hold     = 1'b1;
    end else if (paused_q) begin
      hold    = 1'b1;
      blink_d = (blink_q == CntW'(TICK_DIV - 1)) ? '0 : blink_q + CntW'(1);
    end
`endif
    if (busy) begin
      if (hold) begin
        cnt_d = cnt_q;
      end else if (tick) begin
        if (secs_q > 8'd1) begin
          secs_d = secs_q - 8'd1;
        end else begin
          nxt     = (state_q == StSpin) ? StDone : first_phase(mode_q, state_e'(state_q + 3'd1));
          state_d = nxt;
          secs_d  = phase_time(mode_q, nxt);
          done_d  = (nxt == StDone);
        end
      end
    end else if (bus.start) begin
      mode_d = bus.mode;
      cnt_d  = '0;
      if (bus.bal_in < cost(bus.mode)) begin
        state_d = StErr;
        bal_d   = bus.bal_in;
        secs_d  = 8'd0;
      end else begin
        bal_d   = bus.bal_in - cost(bus.mode);
        nxt     = first_phase(bus.mode, StWash);
        state_d = nxt;
        secs_d  = phase_time(bus.mode, nxt);
        done_d  = (nxt == StDone);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      secs_q   <= 8'd0;
      bal_q    <= 10'd0;
      mode_q   <= 2'd0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef WCC_PAUSE_EN
      paused_q <= 1'b0;
      blink_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      secs_q   <= secs_d;
      bal_q    <= bal_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef WCC_PAUSE_EN
      paused_q <= paused_d;
      blink_q  <= blink_d;
`endif
    end
  end

  always_comb begin
    led_on = 3'b000;
    case (state_q)
      StWash:  led_on = 3'b001;
      StRinse: led_on = 3'b010;
      StSpin:  led_on = 3'b100;
      default: led_on = 3'b000;
    endcase
`ifdef WCC_PAUSE_EN
    // Blink: lit for the first half of each tick period while paused.
    if (paused_q && blink_q >= CntW'(TICK_DIV / 2)) begin
      led_on = 3'b000;
    end
`endif
  end

  assign bus.phase   = state_q;
  assign bus.secs    = secs_q;
  assign bus.bal_out = bal_q;
  assign bus.led     = led_on;
  assign bus.busy    = busy;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: timeline model of the run plus directed scenarios.
module tb_wash_cycle_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wash_cycle_ctrl_if bus();

  wash_cycle_ctrl #(
    .TICK_DIV(TD), .COST0(10), .COST1(20), .COST2(30), .COST3(5),
    .T_W0(10), .T_R0(5),  .T_S0(5),  .T_W1(20), .T_R1(10), .T_S1(10),
    .T_W2(30), .T_R2(15), .T_S2(15), .T_W3(0),  .T_R3(0),  .T_S3(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tables straight from the mode definitions.
  int cost_t[4] = '{10, 20, 30, 5};
  int tw[4]     = '{10, 20, 30, 0};
  int tr[4]     = '{5, 10, 15, 0};
  int ts[4]     = '{5, 10, 15, 10};

  function automatic int total(input int m);
    return tw[m] + tr[m] + ts[m];
  endfunction

  // Position in the run after t counting cycles: phase code or seconds left.
  function automatic int run_pos(input int m, input int t, input bit want_secs);
    int rem = t / TD;
    int times[3];
    times = '{tw[m], tr[m], ts[m]};
    for (int p = 0; p < 3; p++) begin
      if (rem < times[p]) return want_secs ? times[p] - rem : p + 1;
      rem -= times[p];
    end
    return want_secs ? 0 : 4;
  endfunction

  // Model: a run is just a count of elapsed counting cycles since the accepted start.
  bit m_run = 0, m_done = 0, m_paused = 0;
  int m_state = 0, m_mode = 0, m_t = 0, m_bal = 0, m_bcnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 0; m_done <= 0; m_paused <= 0;
      m_state <= 0; m_mode <= 0; m_t <= 0; m_bal <= 0; m_bcnt <= 0;
    end else begin
      m_done <= 0;
      if (m_run) begin
`ifdef WCC_PAUSE_EN
        if (bus.pause) begin
          m_paused <= !m_paused;
          m_bcnt   <= 0;
        end else if (m_paused) begin
          m_bcnt <= (m_bcnt + 1) % TD;
        end else
`endif
        begin
          m_t <= m_t + 1;
          if ((m_t + 1) / TD >= total(m_mode)) begin
            m_run <= 0; m_state <= 4; m_done <= 1; m_paused <= 0;
          end
        end
      end else if (bus.start) begin
        if (int'(bus.bal_in) < cost_t[bus.mode]) begin
          m_state <= 5;
          m_bal   <= bus.bal_in;
        end else begin
          m_bal  <= bus.bal_in - cost_t[bus.mode];
          m_mode <= bus.mode;
          m_t    <= 0;
          if (total(bus.mode) == 0) begin
            m_state <= 4; m_done <= 1;
          end else begin
            m_run <= 1;
          end
        end
      end
    end
  end

  int e_phase, e_secs, e_led;
  always_comb begin
    e_phase = m_state;
    e_secs  = 0;
    e_led   = 0;
    if (m_run) begin
      e_phase = run_pos(m_mode, m_t, 0);
      e_secs  = run_pos(m_mode, m_t, 1);
      e_led   = 1 << (e_phase - 1);
      if (m_paused && m_bcnt >= TD / 2) e_led = 0;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_phase", bus.phase, e_phase);
      chk("cyc_secs", bus.secs, e_secs);
      chk("cyc_bal", bus.bal_out, m_bal);
      chk("cyc_led", bus.led, e_led);
      chk("cyc_busy", bus.busy, m_run);
      chk("cyc_done", bus.done, m_done);
    end
  end

  task automatic pulse_start(input int m, input int b);
    bus.mode = 2'(m); bus.bal_in = 10'(b); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.pause = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_phase(input int p, input string nm);
    int n = 0;
    while (int'(bus.phase) != p && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.phase, p);
  endtask

  task automatic wait_secs(input int s, input string nm);
    int n = 0;
    while (int'(bus.secs) != s && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.secs, s);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, bus.phase, 0);
    chk({tag, "_bal"}, bus.bal_out, 0);
    chk({tag, "_secs"}, bus.secs, 0);
    chk({tag, "_led"}, bus.led, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.mode = 2'd0; bus.bal_in = 10'd0; bus.pause = 1'b0;
    @(posedge clk);
    cmp_en = 1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    #2 rst = 1'b1;
    @(negedge clk);

    // Quick mode, full run.
    pulse_start(0, 25);
    chk("t1_bal", bus.bal_out, 15);
    chk("t1_secs", bus.secs, 10);
    chk("t1_led", bus.led, 3'b001);
    wait_done(n);
    chk("t1_done_latency", n, 80);
    chk("t1_done_phase", bus.phase, 4);
    @(negedge clk);
    chk("t1_done_pulse", bus.done, 0);

    // Restart from DONE.
    pulse_start(1, 20);
    chk("t6_bal", bus.bal_out, 0);
    chk("t6_secs", bus.secs, 20);
    chk("t6_phase", bus.phase, 1);

    // Start while busy is ignored; reset mid-RINSE aborts.
    repeat (10) @(negedge clk);
    pulse_start(2, 500);
    chk("t4_bal_kept", bus.bal_out, 0);
    chk("t4_phase_kept", bus.phase, 1);
    wait_phase(2, "t4_reach_rinse");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("t4_rst");
    #2 rst = 1'b1;
    @(negedge clk);

    // Insufficient balance, then exact balance.
    pulse_start(2, 29);
    chk("t2_err_phase", bus.phase, 5);
    chk("t2_err_bal", bus.bal_out, 29);
    @(negedge clk);
    pulse_start(2, 30);
    chk("t2_phase", bus.phase, 1);
    chk("t2_secs", bus.secs, 30);
    chk("t2_bal", bus.bal_out, 0);
`ifndef WCC_PAUSE_EN
    repeat (9) @(negedge clk);
    pulse_pause();
`endif
    wait_done(n);
    chk("t2_done_seen", bus.done, 1);

    // Mode 3 skips WASH and RINSE.
    @(negedge clk);
    pulse_start(3, 5);
    chk("t3_phase", bus.phase, 3);
    chk("t3_secs", bus.secs, 10);
    chk("t3_led", bus.led, 3'b100);
    chk("t3_bal", bus.bal_out, 0);
    wait_done(n);
    chk("t3_done_latency", n, 40);

    // Pause behaviour (ignored in the default build).
    @(negedge clk);
    pulse_start(0, 10);
    wait_secs(7, "t5_reach7");
    pulse_pause();
`ifdef WCC_PAUSE_EN
    repeat (20) @(negedge clk);
    chk("t5_hold", bus.secs, 7);
    pulse_pause();
    wait_secs(6, "t5_resume");
`endif
    wait_done(n);
    chk("t5_done_seen", bus.done, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
